vga_scan_ctrl: RTL and testbench
================================

Name: vga_scan_ctrl

Overview:
- Raster-scan controller for the single-port VGA frame buffer.
- Generates VGA horizontal/vertical timing and issues one buffer read per active pixel.
- Arbitrates the same buffer port between scan reads and CPU pixel writes; scan reads have absolute priority.
- Sits between the SoC VGA MMIO write path and the frame-buffer memory; drives the display pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- ADDR_W, 19, frame-buffer word-address width

Ports:
- clock  in  1  system clock; one pixel per cycle
- reset  in  1  asynchronous, active-high
- en  in  1  scan enable
- wr_valid  in  1  CPU write request
- wr_ready  out  1  write accepted this cycle
- wr_addr  in  32  CPU byte address, offset from buffer base
- wr_data  in  32  write data
- wr_mask  in  4  byte mask
- buf_addr  out  ADDR_W  buffer word address
- buf_ren  out  1  buffer read strobe
- buf_wen  out  1  buffer write strobe
- buf_wdata  out  32  buffer write data
- buf_wmask  out  4  buffer byte mask
- buf_rdata  in  32  read data, valid the cycle after buf_ren
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- pix_valid  out  1  display-enable, aligned with pix_data
- pix_data  out  24  RGB888, {R,G,B} = buf_rdata[23:0]
- irq  out  1  frame interrupt; present only with the optional feature
- irq_clr  in  1  interrupt clear; present only with the optional feature

Behaviour:
- Clock and reset: one clock domain, clock; reset is asynchronous and active-high.
- Reset values: h_cnt=0, v_cnt=0, line_base=0, hsync=1, vsync=1, pix_valid=0, irq=0. pix_data reads 0 whenever pix_valid=0.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counters: h_cnt wraps H_TOTAL-1→0 and increments v_cnt; v_cnt wraps V_TOTAL-1→0.
- Active region: act = en && h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- Scan read: when act, buf_ren=1 and buf_addr = line_base + h_cnt (combinational).
- Line base: a running register, no multiplier.
  - At h_cnt==H_TOTAL-1 with v_cnt<V_ACTIVE: line_base += H_ACTIVE.
  - At v_cnt wrap: line_base = 0.
- Output registers (1-cycle latency, aligned with buf_rdata):
  - pix_valid <= act
  - hsync <= !(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC))
  - vsync <= !(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC))
- pix_data = pix_valid ? buf_rdata[23:0] : 0.
- Arbitration:
  - wr_ready = !act, combinational.
  - On wr_valid && wr_ready: buf_wen=1, buf_addr = wr_addr[ADDR_W+1:2], buf_wdata=wr_data, buf_wmask=wr_mask.
  - buf_ren and buf_wen are never both 1 in the same cycle.
- A write stalled by an active scan stays pending; the requester holds wr_valid and all payload stable until wr_ready.
- en low: counters, line_base and all output registers clear to their reset values on the next edge; wr_ready=1 every cycle.
- en rising: scan restarts at (0,0) on the following cycle.
- en falling mid-frame: the scan aborts with no partial-line completion. A read issued in the last enabled cycle is discarded (pix_valid clears).
- Reset mid-frame: same as en falling, but asynchronous.
- wr_addr bits beyond ADDR_W+1 are ignored; the address wraps modulo 2^ADDR_W words.

Optional Feature:
- Macro: VGA_SCAN_CTRL_FRAME_IRQ_EN.
- Defined:
  - irq sets on the cycle v_cnt transitions V_ACTIVE-1→V_ACTIVE (start of vertical blanking).
  - irq stays set until an irq_clr pulse.
  - If set and clear coincide, set wins.
- Undefined: irq and irq_clr ports are absent; no interrupt logic is built.

Decomposition:
- Package vga_pkg:
  - default timing localparams (640x480@60)
  - RGB888 pixel typedef
  - H_TOTAL/V_TOTAL helper functions
- One natural sub-module: vga_timing_gen (h/v counters, act, sync decode).
- The top module holds line_base, arbitration and the output registers.

Test Plan:
- Timing, params H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, en=1 → hsync low exactly 2 of every 8 cycles; vsync low for 8 cycles per 48-cycle frame.
- Scan addresses, same params, buffer model returns rdata=addr → pix_data sequence 0,1,2,3 / 4,5,6,7 / 8..11. pix_valid high for 12 cycles per frame; line_base back to 0 next frame.
- Arbitration: wr_valid held from h_cnt=0, wr_addr=0x14, wr_data=0xAABBCC, mask=0xF → wr_ready=0 for 4 active cycles, then one buf_wen with buf_addr=5. Bench asserts ren&wen never coincide.
- Masked write in blanking: wr_mask=4'b0010 → buf_wmask=0010 passed through the same cycle; wr_ready=1.
- en/reset mid-frame: deassert en at (2,1) → next cycle counters 0, pix_valid=0, hsync=vsync=1. Re-enable → first buf_addr=0. Async reset mid-line: outputs clear without a clock edge.
- With VGA_SCAN_CTRL_FRAME_IRQ_EN: irq rises when v_cnt reaches 3 and stays high until irq_clr. irq_clr coinciding with the next set leaves irq=1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), pixel type and frame-total helpers.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_ADDR_W   = 19;

    // Wide enough for any horizontal or vertical total up to 4095.
    localparam int CNT_W = 12;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with active-region and sync-window decode.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] h_cnt,
    output logic             act,
    output logic             h_last,
    output logic             v_last,
    output logic             line_active,
    output logic             hsync_on,
    output logic             vsync_on,
    output logic             blank_start
);

    localparam logic [CNT_W-1:0] HA       = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VA       = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VA_LAST  = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] v_cnt;

    // Disabling the scan parks both counters at the origin so re-enable starts a clean frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        h_last      = (h_cnt == H_LAST);
        v_last      = (v_cnt == V_LAST);
        line_active = (v_cnt < VA);
        act         = en && (h_cnt < HA) && line_active;
        hsync_on    = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vsync_on    = (v_cnt >= VS_START) && (v_cnt < VS_END);
        blank_start = en && h_last && (v_cnt == VA_LAST);
    end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster-scan controller sharing one frame-buffer port between scan reads and CPU writes.
// Optional frame interrupt built when VGA_SCAN_CTRL_FRAME_IRQ_EN is defined.
module vga_scan_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [31:0]       wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [3:0]        wr_mask,
    output logic [ADDR_W-1:0] buf_addr,
    output logic              buf_ren,
    output logic              buf_wen,
    output logic [31:0]       buf_wdata,
    output logic [3:0]        buf_wmask,
    input  logic [31:0]       buf_rdata,
    output logic              hsync,
    output logic              vsync,
    output logic              pix_valid,
    output logic [23:0]       pix_data
`ifdef VGA_SCAN_CTRL_FRAME_IRQ_EN
    ,
    output logic              irq,
    input  logic              irq_clr
`endif
);

    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

    logic [CNT_W-1:0]  h_cnt;
    logic              act, h_last, v_last, line_active;
    logic              hsync_on, vsync_on, blank_start;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] scan_addr;
    rgb888_t           pix_word;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .h_cnt       (h_cnt),
        .act         (act),
        .h_last      (h_last),
        .v_last      (v_last),
        .line_active (line_active),
        .hsync_on    (hsync_on),
        .vsync_on    (vsync_on),
        .blank_start (blank_start)
    );

    // Running start-of-line address: one add per visible line instead of v_cnt*H_ACTIVE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_base <= '0;
        end else if (!en) begin
            line_base <= '0;
        end else if (h_last) begin
            if (v_last) begin
                line_base <= '0;
            end else if (line_active) begin
                line_base <= line_base + LINE_STEP;
            end
        end
    end

    assign scan_addr = line_base + ADDR_W'(h_cnt);

    // Scan owns the port whenever it is in the visible region; CPU writes fill the gaps.
    always_comb begin
        buf_ren   = act;
        wr_ready  = !act;
        buf_wen   = wr_valid && !act;
        buf_addr  = act ? scan_addr : wr_addr[ADDR_W+1:2];
        buf_wdata = wr_data;
        buf_wmask = wr_mask;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_valid <= 1'b0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
        end else begin
            pix_valid <= act;
            hsync     <= !(en && hsync_on);
            vsync     <= !(en && vsync_on);
        end
    end

    assign pix_word = rgb888_t'(buf_rdata[23:0]);
    assign pix_data = pix_valid ? pix_word : 24'h0;

`ifdef VGA_SCAN_CTRL_FRAME_IRQ_EN
    // Set has priority over a coincident clear so a new frame event is never lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (!en) begin
            irq <= 1'b0;
        end else if (blank_start) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

    logic unused_bits;
    assign unused_bits = ^{wr_addr[31:ADDR_W+2], wr_addr[1:0], buf_rdata[31:24], blank_start};

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl on a tiny 8x6 raster (4x3 visible); irq checks when VGA_SCAN_CTRL_FRAME_IRQ_EN is defined.
module tb_vga_scan_ctrl;

    localparam int AW = 19;

    logic          clock = 1'b0;
    logic          reset, en, wr_valid, wr_ready;
    logic [31:0]   wr_addr, wr_data;
    logic [3:0]    wr_mask;
    logic [AW-1:0] buf_addr;
    logic          buf_ren, buf_wen;
    logic [31:0]   buf_wdata;
    logic [3:0]    buf_wmask;
    logic [31:0]   buf_rdata = 32'h0;
    logic          hsync, vsync, pix_valid;
    logic [23:0]   pix_data;
`ifdef VGA_SCAN_CTRL_FRAME_IRQ_EN
    logic          irq, irq_clr;
`endif

    int vec_cnt   = 0;
    int err_cnt   = 0;
    int conflicts = 0;

    always #5 clock = ~clock;

    vga_scan_ctrl #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .ADDR_W   (AW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
        .buf_addr  (buf_addr),
        .buf_ren   (buf_ren),
        .buf_wen   (buf_wen),
        .buf_wdata (buf_wdata),
        .buf_wmask (buf_wmask),
        .buf_rdata (buf_rdata),
        .hsync     (hsync),
        .vsync     (vsync),
        .pix_valid (pix_valid),
        .pix_data  (pix_data)
`ifdef VGA_SCAN_CTRL_FRAME_IRQ_EN
        ,
        .irq       (irq),
        .irq_clr   (irq_clr)
`endif
    );

    // Frame-buffer model: each word holds its own address, one-cycle read latency.
    always @(posedge clock) begin
        if (buf_ren) buf_rdata <= {{(32-AW){1'b0}}, buf_addr};
    end

    always begin
        @(negedge clock);
        #3;
        if (buf_ren && buf_wen) conflicts++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h, v, pv_hi, hs_lo, vs_lo;
        int prev_h, prev_v;
        bit act, prev_act;

        reset = 1'b1; en = 1'b0; wr_valid = 1'b0;
        wr_addr = '0; wr_data = '0; wr_mask = '0;
`ifdef VGA_SCAN_CTRL_FRAME_IRQ_EN
        irq_clr = 1'b0;
`endif
        repeat (2) @(negedge clock);
        #1;
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_ren", buf_ren, 0);
        check("rst_wr_ready", wr_ready, 1);
`ifdef VGA_SCAN_CTRL_FRAME_IRQ_EN
        check("rst_irq", irq, 0);
`endif
        $display("reset state checked");

        // Scan disabled: writes go straight through.
        @(negedge clock);
        reset = 1'b0; wr_valid = 1'b1; wr_addr = 32'h8; wr_data = 32'h55; wr_mask = 4'hF;
        #1;
        check("idle_wr_ready", wr_ready, 1);
        check("idle_wen", buf_wen, 1);
        check("idle_addr", buf_addr, 2);
        $display("idle write addr=0x8 checked");

        // Two full frames from (0,0).
        @(negedge clock);
        wr_valid = 1'b0; en = 1'b1;
        prev_h = 0; prev_v = 0; prev_act = 0;
        pv_hi = 0; hs_lo = 0; vs_lo = 0;
        for (int k = 0; k < 96; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            h = k % 8;
            v = (k / 8) % 6;
            act = (h < 4) && (v < 3);
            check("scan_ren", buf_ren, act);
            check("scan_wr_ready", wr_ready, !act);
            if (act) check("scan_addr", buf_addr, v * 4 + h);
            if (k == 0) begin
                check("scan_pv0", pix_valid, 0);
                check("scan_hs0", hsync, 1);
                check("scan_vs0", vsync, 1);
            end else begin
                check("scan_pix_valid", pix_valid, prev_act);
                check("scan_pix_data", pix_data, prev_act ? prev_v * 4 + prev_h : 0);
                check("scan_hsync", hsync, !(prev_h == 5 || prev_h == 6));
                check("scan_vsync", vsync, !(prev_v == 4));
            end
`ifdef VGA_SCAN_CTRL_FRAME_IRQ_EN
            check("scan_irq", irq, (k >= 24));
`endif
            if (pix_valid) pv_hi++;
            if (!hsync) hs_lo++;
            if (!vsync) vs_lo++;
            if (k % 48 == 47) begin
                check("frame_pv_count", pv_hi, 12);
                check("frame_hs_count", hs_lo, 12);
                check("frame_vs_count", vs_lo, 8);
                $display("frame %0d: pix_valid=%0d hsync_low=%0d vsync_low=%0d", k / 48, pv_hi, hs_lo, vs_lo);
                pv_hi = 0; hs_lo = 0; vs_lo = 0;
            end
            prev_h = h; prev_v = v; prev_act = act;
        end

        // Write held from h=0 of an active line: stalls 4 cycles, lands at h=4.
        @(negedge clock);
        wr_valid = 1'b1; wr_addr = 32'h14; wr_data = 32'h00AABBCC; wr_mask = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            check("arb_stall_ready", wr_ready, 0);
            check("arb_stall_wen", buf_wen, 0);
            check("arb_stall_addr", buf_addr, i);
        end
        @(negedge clock);
        #1;
        check("arb_ready", wr_ready, 1);
        check("arb_wen", buf_wen, 1);
        check("arb_addr", buf_addr, 5);
        check("arb_wdata", buf_wdata, 32'h00AABBCC);
        check("arb_wmask", buf_wmask, 4'hF);
        $display("stalled write addr=0x14 checked");

        @(negedge clock);
        wr_addr = 32'h40; wr_data = 32'h12345678; wr_mask = 4'b0010;
        #1;
        check("mask_ready", wr_ready, 1);
        check("mask_wen", buf_wen, 1);
        check("mask_wmask", buf_wmask, 4'b0010);
        check("mask_addr", buf_addr, 32'h10);
        check("mask_wdata", buf_wdata, 32'h12345678);
        $display("masked blanking write checked");

        @(negedge clock);
        wr_addr = 32'hFFE0_0008; wr_mask = 4'hF;
        #1;
        check("wrap_addr", buf_addr, 2);
        check("wrap_wen", buf_wen, 1);
        $display("address wrap write checked");

        @(negedge clock);
        wr_valid = 1'b0;
        #1;
        check("idle_wen_low", buf_wen, 0);

        // en dropped during (2,1).
        @(negedge clock);
        #1;
        check("line1_addr", buf_addr, 4);
        repeat (2) @(negedge clock);
        #1;
        check("abort_pre_addr", buf_addr, 6);
        en = 1'b0;
        #1;
        check("abort_ren", buf_ren, 0);
        check("abort_wr_ready", wr_ready, 1);
        @(negedge clock);
        #1;
        check("abort_pix_valid", pix_valid, 0);
        check("abort_pix_data", pix_data, 0);
        check("abort_hsync", hsync, 1);
        check("abort_vsync", vsync, 1);
        check("abort_wr_ready2", wr_ready, 1);
        @(negedge clock);
        en = 1'b1;
        #1;
        check("reen_ren", buf_ren, 1);
        check("reen_addr", buf_addr, 0);
        @(negedge clock);
        #1;
        check("reen_addr1", buf_addr, 1);
        $display("en abort and restart checked");

        // Asynchronous reset at h=6 while hsync is low.
        repeat (5) @(negedge clock);
        #1;
        check("pre_rst_hsync", hsync, 0);
        check("pre_rst_ren", buf_ren, 0);
        reset = 1'b1;
        #1;
        check("arst_hsync", hsync, 1);
        check("arst_ren", buf_ren, 1);
        check("arst_addr", buf_addr, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("pre_rst2_pv", pix_valid, 1);
        reset = 1'b1;
        #1;
        check("arst_pix_valid", pix_valid, 0);
        check("arst_pix_data", pix_data, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        $display("async reset mid-line checked");

`ifdef VGA_SCAN_CTRL_FRAME_IRQ_EN
        check("irq_start", irq, 0);
        for (int k = 1; k <= 73; k++) begin
            @(negedge clock);
            if (k == 71) irq_clr = 1'b1;
            if (k == 73) irq_clr = 1'b0;
            #1;
            if (k == 23) check("irq_before_blank", irq, 0);
            if (k == 24) check("irq_set", irq, 1);
            if (k == 60) check("irq_hold", irq, 1);
            if (k == 72) check("irq_set_wins", irq, 1);
            if (k == 73) check("irq_cleared", irq, 0);
        end
        $display("frame irq set/hold/clear checked");
`endif

        check("ren_wen_exclusive", conflicts, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
